// File: rtl/seq_det_param.sv
// Runtime-programmable serial pattern detector with valid qualification,
// saturating match counter and registered match pulse.
// Optional feature: define SEQ_DET_STICKY_EN to add sticky_clr / match_sticky.
module seq_det_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               sequence_in,
  input  logic               count_clr,
`ifdef SEQ_DET_STICKY_EN
  input  logic               sticky_clr,
  output logic               match_sticky,
`endif
  output logic               detector_out,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_FILL     = 2'd1,
    ST_ARMED    = 2'd2
  } state_t;

  state_t             state_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic               det_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               armed_q;

  logic [LEN_W-1:0]   len_clamped;
  logic [MAX_LEN-1:0] hist_d;
  logic [LEN_W-1:0]   fill_d;
  logic [MAX_LEN-1:0] len_mask;
  logic               window_hit;
  logic               bit_accept;
  logic               match;
  logic [CNT_W-1:0]   cnt_inc;

  always_comb begin
    len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
    hist_d      = {hist_q[MAX_LEN-2:0], sequence_in};
    fill_d      = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    len_mask    = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    // Only the low len bits of the window take part in the compare.
    window_hit  = ((hist_d ^ pattern_q) & len_mask) == '0;
    bit_accept  = in_valid && (state_q != ST_DISABLED);
    match       = bit_accept && (fill_d == len_q) && window_hit;
    cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_DISABLED;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      det_q     <= 1'b0;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      len_q     <= len_clamped;
      overlap_q <= cfg_overlap;
      hist_q    <= '0;
      fill_q    <= '0;
      det_q     <= 1'b0;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      state_q   <= (len_clamped == '0) ? ST_DISABLED : ST_FILL;
    end else begin
      det_q <= match;

      if (count_clr) begin
        cnt_q <= match ? CNT_W'(1) : '0;
      end else if (match) begin
        cnt_q <= cnt_inc;
      end

      case (state_q)
        ST_DISABLED: begin
          armed_q <= 1'b0;
        end
        ST_FILL, ST_ARMED: begin
          if (bit_accept) begin
            hist_q <= hist_d;
            // Non-overlapping mode needs len fresh bits before the next match.
            if (match && !overlap_q) begin
              fill_q  <= '0;
              state_q <= ST_FILL;
              armed_q <= 1'b0;
            end else begin
              fill_q <= fill_d;
              if (fill_d == len_q) begin
                state_q <= ST_ARMED;
                armed_q <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= ST_DISABLED;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_DET_STICKY_EN
  logic sticky_q;

  // A match in the same cycle as sticky_clr wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else if (cfg_load) begin
      sticky_q <= 1'b0;
    end else if (match) begin
      sticky_q <= 1'b1;
    end else if (sticky_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign match_sticky = sticky_q;
`endif

  assign detector_out = det_q;
  assign match_count  = cnt_q;
  assign armed        = armed_q;

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
- Runtime-programmable serial bit-pattern detector. Successor to the fixed 4-bit "1011" Moore detector.
- Pattern value, pattern length (1..MAX_LEN) and overlap mode load through a config strobe, not hard-coded states.
- Adds input-valid qualification, a saturating match counter and a registered one-cycle match pulse.
- Sits on the serial input stream next to the framing/sync logic of the design.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of the match counter.
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived, do not override).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- cfg_load  input  1  load pattern/len/overlap config this cycle
- cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
- cfg_len  input  LEN_W  pattern length; 0 = disabled, >MAX_LEN clamps to MAX_LEN
- cfg_overlap  input  1  1 = overlapping matches allowed, 0 = window restarts after a match
- in_valid  input  1  sequence_in is sampled only when high
- sequence_in  input  1  serial data bit
- count_clr  input  1  synchronous clear of match_count
- detector_out  output  1  registered one-cycle match pulse
- match_count  output  CNT_W  saturating count of matches
- armed  output  1  high when history holds at least len valid bits

Behaviour:
- Reset:
  - pattern, len, overlap and history registers = 0.
  - fill counter = 0; FSM = DISABLED.
  - detector_out = 0, match_count = 0, armed = 0.
- Config load (cfg_load=1):
  - Latches cfg_pattern, the clamped cfg_len and cfg_overlap.
  - Clears history, fill, detector_out and match_count.
  - Next state = DISABLED if len==0, else FILL.
  - cfg_load has priority over in_valid and count_clr in the same cycle; the data bit that cycle is discarded.
- History update:
  - On each accepted bit (in_valid=1): hist <= {hist[MAX_LEN-2:0], sequence_in}. hist[0] is the newest bit.
  - fill increments, saturating at len.
- FSM states:
  - DISABLED: ignores data; detector_out stays 0.
  - FILL: fill<len; no match is possible. Moves to ARMED on the accepted bit that makes fill==len.
  - ARMED: armed=1. Evaluates a match on every accepted bit.
- Match rule:
  - The window is the updated history (including the bit just accepted).
  - Match when fill_next>=len and window[len-1:0]==pattern[len-1:0]. Unused high bits are ignored.
- Match latency:
  - detector_out=1 in the cycle immediately after the clock edge that accepted the final pattern bit.
  - Pulse lasts exactly one cycle; no combinational path from sequence_in to detector_out.
- Overlap:
  - overlap=1: history is kept, so the next match can reuse trailing bits.
  - overlap=0: on a match, fill is cleared to 0 and the FSM returns to FILL. The next match needs len fresh bits.
- in_valid=0:
  - History, fill and FSM hold.
  - detector_out drops to 0 after any pulse.
- Counter:
  - match_count increments on each match and saturates at 2^CNT_W-1.
  - count_clr zeroes it. If count_clr and a match coincide, the result is 1 (clear, then count).
- len==1: every accepted bit equal to pattern[0] is a match. overlap has no effect beyond the fill clear.
- Mid-stream reset: immediate return to reset values; the partial window is lost.

Optional Feature:
- Macro: SEQ_DET_STICKY_EN.
- Defined:
  - Adds input sticky_clr (1) and output match_sticky (1).
  - match_sticky sets on any match and holds until sticky_clr=1 or cfg_load or reset.
  - sticky_clr and a match in the same cycle leave match_sticky = 1 (set wins).
- Not defined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset during ARMED with history full -> next cycle: detector_out=0, match_count=0, armed=0; then 4 valid bits 1,0,1,1 with pattern=4'b1011, len=4 give no match until re-armed.
- Load pattern=4'b1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 with in_valid=1 -> detector_out pulses the cycle after bit 4 and after bit 7; match_count=2.
- Same stream with overlap=0 -> single pulse after bit 4; match_count=1; bits 5-7 only refill.
- pattern=8'hA5, len=8; stream 1010_0101 with in_valid deasserted for 3 cycles between bits 4 and 5 -> exactly one pulse, one cycle after bit 8 is accepted; armed rises on the same edge.
- len=1, pattern[0]=1, CNT_W=2; feed seven 1s -> seven pulses; match_count saturates at 3. Then count_clr together with a match -> match_count=1.
- cfg_load asserted in the same cycle as the final matching bit -> no pulse, match_count=0, state=FILL. With SEQ_DET_STICKY_EN, match_sticky stays set after a match until sticky_clr.
